// File: rtl/phase_sequencer.sv
// One-hot phase sequencer for the multi-cycle CPU. It steps FETCH..WB with a
// per-opcode phase set, and supports run, single-step, stall and an illegal-op trap.
module phase_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             stall,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  output logic [4:0]       p,
  output logic             busy,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic             oneshot_r;
  logic             oneshot_nx_s;
  logic [CNT_W-1:0] instret_r;
  logic [3:0]       cls_s;
  logic             last_s;
  logic             done_s;
  logic             active_s;

  // Phase set of an instruction: {legal, uses EXEC, uses MEM, uses WB}.
  function automatic logic [3:0] class_decode(input logic [5:0] o, input logic [5:0] f);
    logic [3:0] c;
    casez (o)
      6'b000000:         c = (f == 6'b001000) ? 4'b1000 : 4'b1101;
      6'b100011:         c = 4'b1111;
      6'b101011:         c = 4'b1110;
      6'b000100,
      6'b000101:         c = 4'b1100;
      6'b001???:         c = 4'b1101;
      6'b000010:         c = 4'b1000;
      6'b000011:         c = 4'b1001;
      default:           c = 4'b0000;
    endcase
    return c;
  endfunction

  assign cls_s = class_decode(op, func);

  // Next-state, one-shot flag and end-of-instruction detection.
  always_comb begin
    state_nx_s   = state_r;
    oneshot_nx_s = oneshot_r;
    last_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (run) begin
          state_nx_s   = S_FETCH;
          oneshot_nx_s = 1'b0;
        end else if (step) begin
          state_nx_s   = S_FETCH;
          oneshot_nx_s = 1'b1;
        end else begin
          state_nx_s   = S_IDLE;
        end
      end
      S_FETCH:  state_nx_s = S_DECODE;
      S_DECODE: begin
        if (!cls_s[3]) begin
          state_nx_s = S_HALT;
        end else if (cls_s[2]) begin
          state_nx_s = S_EXEC;
        end else if (cls_s[0]) begin
          state_nx_s = S_WB;
        end else begin
          last_s = 1'b1;
        end
      end
      S_EXEC: begin
        if (cls_s[1]) begin
          state_nx_s = S_MEM;
        end else if (cls_s[0]) begin
          state_nx_s = S_WB;
        end else begin
          last_s = 1'b1;
        end
      end
      S_MEM: begin
        if (cls_s[0]) begin
          state_nx_s = S_WB;
        end else begin
          last_s = 1'b1;
        end
      end
      S_WB:    last_s = 1'b1;
      S_HALT:  state_nx_s = S_HALT;
      default: state_nx_s = S_IDLE;
    endcase

    done_s = last_s && !stall;
    // A stalled last phase is not done; it simply holds like any other phase.
    if (done_s) begin
      state_nx_s   = (run && !oneshot_r) ? S_FETCH : S_IDLE;
      oneshot_nx_s = 1'b0;
    end else if (stall && active_s) begin
      state_nx_s   = state_r;
      oneshot_nx_s = oneshot_r;
    end else begin
      oneshot_nx_s = oneshot_nx_s;
    end
  end

  // Moore output decode of the state register.
  always_comb begin
    p        = 5'b00000;
    busy     = 1'b0;
    illegal  = 1'b0;
    active_s = 1'b0;
    case (state_r)
      S_FETCH:  begin p = 5'b00001; busy = 1'b1; active_s = 1'b1; end
      S_DECODE: begin p = 5'b00010; busy = 1'b1; active_s = 1'b1; end
      S_EXEC:   begin p = 5'b00100; busy = 1'b1; active_s = 1'b1; end
      S_MEM:    begin p = 5'b01000; busy = 1'b1; active_s = 1'b1; end
      S_WB:     begin p = 5'b10000; busy = 1'b1; active_s = 1'b1; end
      S_HALT:   illegal = 1'b1;
      default:  p = 5'b00000;
    endcase
  end

  assign instr_done = done_s;
  assign instret    = instret_r;

  // State, one-shot flag and retired-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      oneshot_r <= 1'b0;
      instret_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nx_s;
      oneshot_r <= oneshot_nx_s;
      if (done_s) begin
        instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        instret_r <= instret_r;
      end
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: per-cycle expectations are queued when
// an instruction is issued and popped/compared each cycle on the falling edge.
module tb_phase_sequencer;

  localparam logic [4:0] PF = 5'b00001;
  localparam logic [4:0] PD = 5'b00010;
  localparam logic [4:0] PE = 5'b00100;
  localparam logic [4:0] PM = 5'b01000;
  localparam logic [4:0] PW = 5'b10000;

  logic        clk = 1'b0;
  logic        reset, run, step, stall;
  logic [5:0]  op, func;
  logic [4:0]  p, p_w;
  logic        busy, instr_done, illegal, busy_w, done_w, ill_w;
  logic [15:0] instret;
  logic [3:0]  instret_w;

  always #5 clk = ~clk;

  phase_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .stall(stall),
    .op(op), .func(func), .p(p), .busy(busy), .instr_done(instr_done),
    .illegal(illegal), .instret(instret)
  );

  // Narrow-counter copy on the same stimulus to exercise counter wrap quickly.
  phase_sequencer #(.CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .run(run), .step(step), .stall(stall),
    .op(op), .func(func), .p(p_w), .busy(busy_w), .instr_done(done_w),
    .illegal(ill_w), .instret(instret_w)
  );

  typedef struct packed {
    logic [4:0]  p;
    logic        busy;
    logic        done;
    logic        ill;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  func;
    logic [24:0] seq;
    int          len;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[10];
  int          n_pass = 0;
  int          n_tot  = 0;
  logic [15:0] cnt    = 16'd0;

  task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s/%s: got %0h expected %0h", tag, fld, act, exp);
  endtask

  function automatic exp_t mk(input logic [4:0] pp, input logic b, input logic d,
                              input logic i, input logic [15:0] c);
    exp_t e;
    e.p = pp; e.busy = b; e.done = d; e.ill = i; e.cnt = c;
    return e;
  endfunction

  task automatic pop_check(input string tag);
    exp_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_tot++;
      $display("FAIL %s/queue: got empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, "p", p, e.p);
      chk(tag, "busy", busy, e.busy);
      chk(tag, "instr_done", instr_done, e.done);
      chk(tag, "illegal", illegal, e.ill);
      chk(tag, "instret", instret, e.cnt);
      chk(tag, "instret_w", instret_w, e.cnt[3:0]);
      chk(tag, "p_w", p_w, e.p);
    end
    @(posedge clk); #1;
  endtask

  // mode 0: single-step from IDLE; 1: run, stay running; 2: run, drop run in FETCH.
  task automatic do_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                          input logic [24:0] seq, input int len, input int mode,
                          input int step_at, input int stall_at, input int stall_n);
    op = o; func = f;
    if (mode == 0) begin
      run = 1'b0; step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
    end else if (mode == 2) begin
      run = 1'b0;
    end
    for (int k = 0; k < len; k++) begin
      if (k == stall_at)
        for (int s = 0; s < stall_n; s++) exp_q.push_back(mk(seq[k*5 +: 5], 1'b1, 1'b0, 1'b0, cnt));
      exp_q.push_back(mk(seq[k*5 +: 5], 1'b1, (k == len - 1), 1'b0, cnt));
    end
    cnt = cnt + 16'd1;
    if (mode != 1) exp_q.push_back(mk(5'b00000, 1'b0, 1'b0, 1'b0, cnt));
    for (int k = 0; k < len; k++) begin
      if (k == step_at) step = 1'b1;
      if (k == stall_at) begin
        stall = 1'b1;
        repeat (stall_n) pop_check(tag);
        stall = 1'b0;
      end
      pop_check(tag);
      step = 1'b0;
    end
    if (mode != 1) pop_check(tag);
  endtask

  initial begin
    vecs[0] = '{6'b100011, 6'b000000, {PW, PM, PE, PD, PF}, 5};
    vecs[1] = '{6'b101011, 6'b000000, {5'b0, PM, PE, PD, PF}, 4};
    vecs[2] = '{6'b000000, 6'b100000, {5'b0, PW, PE, PD, PF}, 4};
    vecs[3] = '{6'b000000, 6'b001000, {15'b0, PD, PF}, 2};
    vecs[4] = '{6'b000100, 6'b000000, {10'b0, PE, PD, PF}, 3};
    vecs[5] = '{6'b000101, 6'b000000, {10'b0, PE, PD, PF}, 3};
    vecs[6] = '{6'b001000, 6'b001000, {5'b0, PW, PE, PD, PF}, 4};
    vecs[7] = '{6'b001101, 6'b000000, {5'b0, PW, PE, PD, PF}, 4};
    vecs[8] = '{6'b000010, 6'b000000, {15'b0, PD, PF}, 2};
    vecs[9] = '{6'b000011, 6'b000000, {10'b0, PW, PD, PF}, 3};

    reset = 1'b0; run = 1'b0; step = 1'b0; stall = 1'b0; op = 6'd0; func = 6'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", "p", p, 5'b00000);
    chk("reset", "busy", busy, 1'b0);
    chk("reset", "instr_done", instr_done, 1'b0);
    chk("reset", "illegal", illegal, 1'b0);
    chk("reset", "instret", instret, 16'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Free-run: lw, add, beq back-to-back, then jr with run dropped mid-instruction.
    op = 6'b100011; run = 1'b1;
    @(posedge clk); #1;
    do_instr("run_lw", 6'b100011, 6'b000000, vecs[0].seq, 5, 1, -1, -1, 0);
    do_instr("run_add", 6'b000000, 6'b100000, vecs[2].seq, 4, 1, -1, -1, 0);
    do_instr("run_beq", 6'b000100, 6'b000000, vecs[4].seq, 3, 1, -1, -1, 0);
    do_instr("run_jr", 6'b000000, 6'b001000, vecs[3].seq, 2, 2, -1, -1, 0);

    // A burst of jumps carries the narrow counter past its wrap point.
    op = 6'b000010; run = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 19; i++) do_instr("run_j", 6'b000010, 6'b000000, vecs[8].seq, 2, 1, -1, -1, 0);
    do_instr("run_j_last", 6'b000010, 6'b000000, vecs[8].seq, 2, 2, -1, -1, 0);

    for (int i = 0; i < 10; i++)
      do_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].func, vecs[i].seq, vecs[i].len, 0, -1, -1, 0);

    // Step during MEM of a single-stepped sw is dropped, not queued.
    do_instr("sw_step", 6'b101011, 6'b000000, vecs[1].seq, 4, 0, 3, -1, 0);
    exp_q.push_back(mk(5'b00000, 1'b0, 1'b0, 1'b0, cnt));
    pop_check("sw_step_idle");

    do_instr("lw_stall_mem", 6'b100011, 6'b000000, vecs[0].seq, 5, 0, -1, 3, 3);
    do_instr("add_stall_wb", 6'b000000, 6'b100000, vecs[2].seq, 4, 0, -1, 3, 2);

    // Asynchronous reset during EXEC.
    op = 6'b100011; func = 6'd0; step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("rst_exec", "p_before", p, PE);
    chk("rst_exec", "instret_before", instret, cnt);
    #2 reset = 1'b0;
    #1;
    chk("rst_exec", "p", p, 5'b00000);
    chk("rst_exec", "busy", busy, 1'b0);
    chk("rst_exec", "instr_done", instr_done, 1'b0);
    chk("rst_exec", "instret", instret, 16'd0);
    chk("rst_exec", "instret_w", instret_w, 4'd0);
    cnt = 16'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.push_back(mk(5'b00000, 1'b0, 1'b0, 1'b0, cnt));
    pop_check("rst_idle");

    // Illegal opcode: trap to HALT, then run/step/stall have no effect.
    do_instr("after_rst", 6'b000011, 6'b000000, vecs[9].seq, 3, 0, -1, -1, 0);
    op = 6'b111111; func = 6'd0; run = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(mk(PF, 1'b1, 1'b0, 1'b0, cnt));
    exp_q.push_back(mk(PD, 1'b1, 1'b0, 1'b0, cnt));
    repeat (4) exp_q.push_back(mk(5'b00000, 1'b0, 1'b0, 1'b1, cnt));
    pop_check("ill_fetch");
    pop_check("ill_decode");
    op = 6'b100011; step = 1'b1;
    pop_check("halt_step");
    step = 1'b0; stall = 1'b1;
    pop_check("halt_stall");
    stall = 1'b0; run = 1'b0;
    pop_check("halt_norun");
    run = 1'b1;
    pop_check("halt_run");
    run = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Generates the one-hot phase vector p[4:0] consumed by the multi-cycle CPU datapath/control.
  - p[0] IF: IR load.
  - p[1] ID: A/B load, PC increment.
  - p[2] EX: ALU, ALUOut load.
  - p[3] MEM.
  - p[4] WB: register-file write.
- Sequence length per instruction is chosen from the opcode/func fields of the IR.
- Supports free-run, single-step, wait-stall and illegal-opcode trap.
- Counts retired instructions.

Parameters:
- CNT_W, 16, width of the retired-instruction counter instret.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  level; while high, instructions issue back-to-back.
- step  input  1  one-cycle pulse; issues exactly one instruction when idle.
- stall  input  1  level; freezes the current phase (memory wait).
- op  input  6  IR[31:26]; valid from the DECODE phase onward.
- func  input  6  IR[5:0]; valid from DECODE onward.
- p  output  5  one-hot phase vector, all-zero when idle or halted.
- busy  output  1  high in any active phase (FETCH..WB).
- instr_done  output  1  high in the final, non-stalled cycle of an instruction.
- illegal  output  1  sticky; set on undefined opcode.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- States:
  - IDLE (p=00000)
  - FETCH (p=00001)
  - DECODE (00010)
  - EXEC (00100)
  - MEM (01000)
  - WB (10000)
  - HALT (00000)
- p, busy and illegal are Moore outputs decoded from the state register. instr_done = (current state is the class's last phase) && !stall.
- Reset (reset=0, asynchronous) forces the following immediately, including mid-instruction:
  - state=IDLE
  - p=0
  - busy=0
  - instr_done=0
  - illegal=0
  - instret=0
  - No partial phase completes.
- IDLE:
  - run=1 -> FETCH next edge.
  - Else step=1 -> FETCH with one-shot flag set.
  - step while not IDLE is ignored and not queued.
- FETCH -> DECODE always.
- Next state from DECODE onward is chosen by class of op, with func used only for op=000000:
  - R-type (op=000000): FETCH, DECODE, EXEC, WB. Exception: func=001000 (jr) ends at DECODE.
  - lw (100011): FETCH, DECODE, EXEC, MEM, WB.
  - sw (101011): FETCH, DECODE, EXEC, MEM.
  - beq (000100), bne (000101): FETCH, DECODE, EXEC.
  - I-type ALU (001xxx): FETCH, DECODE, EXEC, WB.
  - j (000010): FETCH, DECODE.
  - jal (000011): FETCH, DECODE, WB.
  - Any other op: in DECODE, go to HALT next edge, set illegal, no instr_done, instret unchanged.
- After the last phase of an instruction (instr_done=1):
  - instret increments by 1, wrapping modulo 2^CNT_W.
  - Next state is FETCH if run=1 and the one-shot flag is clear; otherwise IDLE.
  - The one-shot flag clears on completion.
- run falling mid-instruction: the current instruction completes, then the sequencer goes to IDLE.
- stall=1 in any active state: state, p and instret hold, and instr_done=0.
  - Stall in the last phase delays instr_done and the increment to the first cycle with stall=0.
  - stall is ignored in IDLE and HALT.
- HALT exits only through reset; run, step and stall have no effect.
- Exactly one p bit is high whenever busy=1; p=0 whenever busy=0.

Test Plan:
- Reset sequence, then run=1, op=100011 (lw): p cycles 00001, 00010, 00100, 01000, 10000. instr_done high only in the WB cycle; instret=1; next cycle p=00001.
- run=1, op=000000, func=100000 (add): 4-cycle sequence skips MEM (00100 -> 10000). op=000100 (beq): 3 cycles, instr_done in EXEC. func=001000 (jr): 2 cycles.
- run=0, step pulse with op=101011 (sw): 4 phases, then IDLE with p=0 and busy=0. A second step pulse during MEM is ignored; instret=1.
- stall=1 for 3 cycles during MEM of lw: p=01000 held 4 cycles total, instr_done=0 throughout; WB follows the stall release, and instret advances once.
- op=111111 while run=1: DECODE -> HALT, illegal=1, p=0, instret unchanged; run/step are ignored until reset.
- Assert reset=0 during EXEC: p=0 and instret=0 asynchronously, before the next clk edge. Preload instret=16'hFFFF via 65535 retirements (or force) and retire one more: instret wraps to 0.
